spi_frame_scheduler: RTL and testbench
======================================

// Module: spi_frame_scheduler
// PURPOSE
//  Sequences the 16-byte sensor frame consumed by the MCU-facing SPI slave.
//  - Holds the latest IMU quaternion/gyro samples and tracks sample freshness.
//  - Detects MCU chip-select (cs_n, async) and freezes one coherent frame per transaction.
//  - Adds a sequence tag and status flags to the frame.
//  - Drives tx_packet and a one-cycle packet_load strobe into the SPI shift datapath.
// PARAMETERS
//  SYNC_STAGES  2      cs_n synchronizer depth (>=2)
//  SEQ_WIDTH    4      frame sequence counter width (fits flags byte low nibble)
// PORTS
//  clk          in   1    FPGA system clock (3 MHz)
//  reset        in   1    synchronous, active-high reset
//  cs_n         in   1    MCU chip select, active low, asynchronous to clk
//  initialized  in   1    sensor init complete (status flag)
//  error        in   1    sensor error (status flag)
//  quat1_valid  in   1    one-cycle strobe: quat1_w/x/y/z valid this cycle
//  quat1_w/x/y/z in  16   signed quaternion components
//  gyro1_valid  in   1    one-cycle strobe: gyro1_x/y/z valid this cycle
//  gyro1_x/y/z  in   16   signed gyro components
//  tx_packet    out  128  frame, byte0 at [127:120], MSB-first per 16-bit field
//  packet_load  out  1    one-cycle pulse: tx_packet just updated, SPI slave reloads shifter
//  busy         out  1    high while a frame is frozen (SNAP/ACTIVE)
//  frame_seq    out  SEQ_WIDTH  sequence tag of the next frame to be issued
// BEHAVIOUR
//  Frame layout:
//   byte0 = 8'hAA
//   bytes1-8 = qw, qx, qy, qz
//   bytes9-14 = gx, gy, gz
//   byte15 = {initialized, error, quat_fresh, gyro_fresh, seq[3:0]}
//  Holding regs:
//   - quat/gyro holding regs load on their valid strobe in every state.
//   - quat_fresh/gyro_fresh set on the matching valid strobe.
//  cs path:
//   - cs_n passes through SYNC_STAGES flops, then an edge-detect flop.
//   - All flops reset to 1 (idle).
//  FSM states: WAIT_IDLE, IDLE, SNAP, ACTIVE. Reset state is WAIT_IDLE.
//   - WAIT_IDLE: move to IDLE once cs_sync==1. No frame may start from a cs_n already low at reset.
//   - IDLE: on cs_sync falling edge -> SNAP.
//   - SNAP (1 cycle):
//     - Register tx_packet from holding regs and fresh flags as they were before this edge.
//     - Clear both fresh flags; packet_load=1 next cycle.
//     - Go to ACTIVE unconditionally.
//   - ACTIVE: tx_packet frozen. On cs_sync==1 -> IDLE, and seq <= seq+1 (wraps modulo 2^SEQ_WIDTH).
//  Latency:
//   - cs_n low is sampled at edge N; tx_packet and packet_load update at edge N+SYNC_STAGES+1.
//   - MCU must wait >= SYNC_STAGES+2 clk periods before the first SCK.
//  Simultaneous events:
//   - valid strobe in the SNAP cycle: the packet gets the old value.
//   - The new value is stored, and fresh stays 1 for the next frame.
//  Frame content: the frame never mixes samples from different valid strobes. It is snapshot-atomic.
//  Reset values:
//   - tx_packet = {8'hAA, 120'h0}; packet_load=0; busy=0; frame_seq=0.
//   - Holding regs and fresh flags = 0.
//  Reset mid-transaction:
//   - Abort to WAIT_IDLE; outputs take reset values.
//   - No packet_load until cs_n is seen high and then falls again.
//  Status capture: initialized/error are sampled in the SNAP cycle, not earlier.
// STRUCTURE
//  Package spi_frame_pkg:
//   - FRAME_HEADER = 8'hAA, FRAME_BYTES = 16.
//   - Byte-offset localparams.
//   - typedef enum {WAIT_IDLE, IDLE, SNAP, ACTIVE} frame_state_t.
//   - Flags-byte struct.
//  Sub-module cs_sync_edge:
//   - SYNC_STAGES synchronizer plus edge detect.
//   - Outputs cs_sync, cs_fall, cs_rise.
// TESTING
//  1. Reset asserted 3 clk -> tx_packet==128'hAA00..00, packet_load=0, busy=0, frame_seq=0.
//  2. Frame capture.
//     - Stimulus: quat {1234,5678,9ABC,DEF0}, gyro {1111,2222,3333} strobed, init=1, err=0; cs_n low.
//     - Response: packet_load pulses exactly once, 3 clk later.
//     - tx_packet == AA_1234_5678_9ABC_DEF0_1111_2222_3333_B0.
//  3. Freeze while cs_n low.
//     - Stimulus: quat1_w=4321 strobed while cs_n low.
//     - Response: tx_packet unchanged; cs_n high then low -> bytes1-2 = 43 21, byte15 = 0xA1 (gyro not fresh, seq=1).
//  4. quat1_valid coincident with SNAP cycle -> packet holds old qw; next frame carries new qw with quat_fresh=1.
//  5. Reset pulsed while cs_n low -> no packet_load until cs_n high >=3 clk then low; frame seq=0.
//  6. 17 back-to-back transactions -> frame seq nibble runs 0..F then 0; exactly one packet_load per transaction.

Source files
------------

// File: rtl/spi_frame_scheduler_pkg.sv
// Shared frame layout, FSM state encoding and flags-byte format for the
// SPI frame scheduler.
package spi_frame_pkg;

   localparam logic [7:0] FRAME_HEADER = 8'hAA;
   localparam int         FRAME_BYTES  = 16;
   localparam int         FRAME_W      = 8 * FRAME_BYTES;

   localparam int HDR_BYTE   = 0;
   localparam int QW_BYTE    = 1;
   localparam int QX_BYTE    = 3;
   localparam int QY_BYTE    = 5;
   localparam int QZ_BYTE    = 7;
   localparam int GX_BYTE    = 9;
   localparam int GY_BYTE    = 11;
   localparam int GZ_BYTE    = 13;
   localparam int FLAGS_BYTE = 15;

   typedef enum logic [1:0] {
      WAIT_IDLE = 2'd0,
      IDLE      = 2'd1,
      SNAP      = 2'd2,
      ACTIVE    = 2'd3
   } frame_state_t;

   typedef struct packed {
      logic       initialized;
      logic       error;
      logic       quat_fresh;
      logic       gyro_fresh;
      logic [3:0] seq;
   } frame_flags_t;

   // Bit index of the MSB of a byte; byte 0 sits at the top of the frame.
   function automatic int field_msb(input int byte_idx);
      return FRAME_W - 1 - 8 * byte_idx;
   endfunction

endpackage

// File: rtl/spi_frame_scheduler_cs_sync_edge.sv
// Chip-select synchronizer followed by a single edge-detect flop.
// Every flop powers up / resets to the idle (high) level.
module cs_sync_edge #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic reset,
   input  logic cs_n,
   output logic cs_sync,
   output logic cs_fall,
   output logic cs_rise
);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   cs_prev_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         sync_q    <= '1;
         cs_prev_q <= 1'b1;
      end else begin
         sync_q    <= {sync_q[SYNC_STAGES-2:0], cs_n};
         cs_prev_q <= sync_q[SYNC_STAGES-1];
      end
   end

   assign cs_sync = sync_q[SYNC_STAGES-1];
   assign cs_fall = cs_prev_q & ~cs_sync;
   assign cs_rise = ~cs_prev_q & cs_sync;

endmodule

// File: rtl/spi_frame_scheduler.sv
// Freezes one coherent 16-byte IMU frame per MCU SPI transaction and
// strobes packet_load so the SPI slave reloads its shifter.
module spi_frame_scheduler
   import spi_frame_pkg::*;
#(
   parameter int SYNC_STAGES = 2,
   parameter int SEQ_WIDTH   = 4
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     cs_n,
   input  logic                     initialized,
   input  logic                     error,
   input  logic                     quat1_valid,
   input  logic signed [15:0]       quat1_w,
   input  logic signed [15:0]       quat1_x,
   input  logic signed [15:0]       quat1_y,
   input  logic signed [15:0]       quat1_z,
   input  logic                     gyro1_valid,
   input  logic signed [15:0]       gyro1_x,
   input  logic signed [15:0]       gyro1_y,
   input  logic signed [15:0]       gyro1_z,
   output logic [FRAME_W-1:0]       tx_packet,
   output logic                     packet_load,
   output logic                     busy,
   output logic [SEQ_WIDTH-1:0]     frame_seq
);

   localparam int                  CNT_W       = $clog2(SYNC_STAGES + 1);
   localparam logic [CNT_W-1:0]    CNT_LAST    = CNT_W'(SYNC_STAGES);
   localparam logic [FRAME_W-1:0]  RESET_FRAME = {FRAME_HEADER, {(FRAME_W-8){1'b0}}};

   logic cs_sync;
   logic cs_fall;
   logic cs_rise;
   logic unused_cs_rise;

   cs_sync_edge #(
      .SYNC_STAGES (SYNC_STAGES)
   ) u_cs_sync_edge (
      .clk     (clk),
      .reset   (reset),
      .cs_n    (cs_n),
      .cs_sync (cs_sync),
      .cs_fall (cs_fall),
      .cs_rise (cs_rise)
   );

   assign unused_cs_rise = cs_rise;

   frame_state_t          state_q;
   logic [CNT_W-1:0]      idle_cnt_q;
   logic [SEQ_WIDTH-1:0]  seq_q;

   logic signed [15:0] quat_w_q, quat_x_q, quat_y_q, quat_z_q;
   logic signed [15:0] gyro_x_q, gyro_y_q, gyro_z_q;
   logic               quat_fresh_q, gyro_fresh_q;

   frame_flags_t       flags;
   logic [FRAME_W-1:0] next_frame;

   always_comb begin
      flags.initialized = initialized;
      flags.error       = error;
      flags.quat_fresh  = quat_fresh_q;
      flags.gyro_fresh  = gyro_fresh_q;
      flags.seq         = 4'(seq_q);

      next_frame = '0;
      next_frame[field_msb(HDR_BYTE)   -: 8]  = FRAME_HEADER;
      next_frame[field_msb(QW_BYTE)    -: 16] = quat_w_q;
      next_frame[field_msb(QX_BYTE)    -: 16] = quat_x_q;
      next_frame[field_msb(QY_BYTE)    -: 16] = quat_y_q;
      next_frame[field_msb(QZ_BYTE)    -: 16] = quat_z_q;
      next_frame[field_msb(GX_BYTE)    -: 16] = gyro_x_q;
      next_frame[field_msb(GY_BYTE)    -: 16] = gyro_y_q;
      next_frame[field_msb(GZ_BYTE)    -: 16] = gyro_z_q;
      next_frame[field_msb(FLAGS_BYTE) -: 8]  = flags;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= WAIT_IDLE;
         idle_cnt_q   <= '0;
         seq_q        <= '0;
         tx_packet    <= RESET_FRAME;
         packet_load  <= 1'b0;
         quat_w_q     <= '0;
         quat_x_q     <= '0;
         quat_y_q     <= '0;
         quat_z_q     <= '0;
         gyro_x_q     <= '0;
         gyro_y_q     <= '0;
         gyro_z_q     <= '0;
         quat_fresh_q <= 1'b0;
         gyro_fresh_q <= 1'b0;
      end else begin
         packet_load <= 1'b0;

         if (quat1_valid) begin
            quat_w_q     <= quat1_w;
            quat_x_q     <= quat1_x;
            quat_y_q     <= quat1_y;
            quat_z_q     <= quat1_z;
            quat_fresh_q <= 1'b1;
         end
         if (gyro1_valid) begin
            gyro_x_q     <= gyro1_x;
            gyro_y_q     <= gyro1_y;
            gyro_z_q     <= gyro1_z;
            gyro_fresh_q <= 1'b1;
         end

         case (state_q)
            // The chain holds its reset value (high) for SYNC_STAGES cycles, so
            // one extra high sample proves cs_n was genuinely seen idle.
            WAIT_IDLE: begin
               if (!cs_sync)
                  idle_cnt_q <= '0;
               else if (idle_cnt_q == CNT_LAST)
                  state_q <= IDLE;
               else
                  idle_cnt_q <= idle_cnt_q + 1'b1;
            end
            IDLE: begin
               if (cs_fall)
                  state_q <= SNAP;
            end
            // A strobe landing in this cycle is kept for the next frame.
            SNAP: begin
               tx_packet    <= next_frame;
               packet_load  <= 1'b1;
               quat_fresh_q <= quat1_valid;
               gyro_fresh_q <= gyro1_valid;
               state_q      <= ACTIVE;
            end
            ACTIVE: begin
               if (cs_sync) begin
                  state_q <= IDLE;
                  seq_q   <= seq_q + 1'b1;
               end
            end
            default: state_q <= WAIT_IDLE;
         endcase
      end
   end

   assign busy      = (state_q == SNAP) || (state_q == ACTIVE);
   assign frame_seq = seq_q;

endmodule

// File: tb/tb_spi_frame_scheduler.sv
// Scoreboard bench for spi_frame_scheduler: expected frames are queued when a
// transaction starts and compared whenever packet_load fires.
module tb_spi_frame_scheduler;

   logic               clk = 1'b0;
   logic               reset;
   logic               cs_n;
   logic               initialized;
   logic               error;
   logic               quat1_valid;
   logic signed [15:0] quat1_w, quat1_x, quat1_y, quat1_z;
   logic               gyro1_valid;
   logic signed [15:0] gyro1_x, gyro1_y, gyro1_z;
   logic [127:0]       tx_packet;
   logic               packet_load;
   logic               busy;
   logic [3:0]         frame_seq;

   spi_frame_scheduler #(
      .SYNC_STAGES (2),
      .SEQ_WIDTH   (4)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .cs_n        (cs_n),
      .initialized (initialized),
      .error       (error),
      .quat1_valid (quat1_valid),
      .quat1_w     (quat1_w),
      .quat1_x     (quat1_x),
      .quat1_y     (quat1_y),
      .quat1_z     (quat1_z),
      .gyro1_valid (gyro1_valid),
      .gyro1_x     (gyro1_x),
      .gyro1_y     (gyro1_y),
      .gyro1_z     (gyro1_z),
      .tx_packet   (tx_packet),
      .packet_load (packet_load),
      .busy        (busy),
      .frame_seq   (frame_seq)
   );

   always #5 clk = ~clk;

   localparam logic [127:0] RESET_FRAME = {8'hAA, 120'h0};

   int           n_checks = 0;
   int           n_errors = 0;
   int           load_cnt = 0;
   int           xact_base;
   logic [127:0] sb_q[$];

   // reference model state
   logic [15:0] m_qw, m_qx, m_qy, m_qz, m_gx, m_gy, m_gz;
   logic        m_qf, m_gf;
   logic [3:0]  m_seq;

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   always @(negedge clk) begin
      if (packet_load === 1'b1) begin
         load_cnt++;
         if (sb_q.size() == 0)
            check("unexpected_load", 128'd1, 128'd0);
         else
            check("frame", tx_packet, sb_q.pop_front());
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [127:0] model_frame();
      logic [7:0] fl;
      fl = {initialized, error, m_qf, m_gf, m_seq};
      return {8'hAA, m_qw, m_qx, m_qy, m_qz, m_gx, m_gy, m_gz, fl};
   endfunction

   task automatic model_reset();
      {m_qw, m_qx, m_qy, m_qz, m_gx, m_gy, m_gz} = '0;
      m_qf  = 1'b0;
      m_gf  = 1'b0;
      m_seq = 4'd0;
   endtask

   task automatic strobe_quat(input logic [15:0] w, x, y, z);
      quat1_w = w; quat1_x = x; quat1_y = y; quat1_z = z;
      quat1_valid = 1'b1;
      tick();
      quat1_valid = 1'b0;
      m_qw = w; m_qx = x; m_qy = y; m_qz = z; m_qf = 1'b1;
   endtask

   task automatic strobe_gyro(input logic [15:0] x, y, z);
      gyro1_x = x; gyro1_y = y; gyro1_z = z;
      gyro1_valid = 1'b1;
      tick();
      gyro1_valid = 1'b0;
      m_gx = x; m_gy = y; m_gz = z; m_gf = 1'b1;
   endtask

   // Drops cs_n and walks to the load edge; optionally strobes a new qw in the SNAP cycle.
   task automatic begin_xact(input bit snap_quat, input logic [15:0] snap_qw);
      sb_q.push_back(model_frame());
      m_qf = 1'b0;
      m_gf = 1'b0;
      xact_base = load_cnt;
      cs_n = 1'b0;
      tick(); tick(); tick();
      check("load_early", {127'd0, packet_load}, 128'd0);
      if (snap_quat) begin
         quat1_w     = snap_qw;
         quat1_valid = 1'b1;
      end
      tick();
      quat1_valid = 1'b0;
      if (snap_quat) begin
         m_qw = snap_qw;
         m_qf = 1'b1;
      end
      check("load_latency", {127'd0, packet_load}, 128'd1);
      check("busy_active", {127'd0, busy}, 128'd1);
      tick();
   endtask

   task automatic end_xact();
      cs_n = 1'b1;
      repeat (6) tick();
      check("loads_per_xact", 128'(load_cnt - xact_base), 128'd1);
      check("busy_idle", {127'd0, busy}, 128'd0);
      m_seq = m_seq + 4'd1;
   endtask

   task automatic do_reset(input int cycles);
      reset = 1'b1;
      repeat (cycles) tick();
      reset = 1'b0;
      model_reset();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int base;
      reset = 1'b0; cs_n = 1'b1; initialized = 1'b0; error = 1'b0;
      quat1_valid = 1'b0; gyro1_valid = 1'b0;
      {quat1_w, quat1_x, quat1_y, quat1_z, gyro1_x, gyro1_y, gyro1_z} = '0;
      model_reset();

      // 1: reset values
      do_reset(3);
      check("rst_tx_packet", tx_packet, RESET_FRAME);
      check("rst_packet_load", {127'd0, packet_load}, 128'd0);
      check("rst_busy", {127'd0, busy}, 128'd0);
      check("rst_frame_seq", {124'd0, frame_seq}, 128'd0);
      repeat (5) tick();

      // 2: frame capture
      initialized = 1'b1; error = 1'b0;
      strobe_quat(16'h1234, 16'h5678, 16'h9ABC, 16'hDEF0);
      strobe_gyro(16'h1111, 16'h2222, 16'h3333);
      tick();
      begin_xact(1'b0, 16'h0);
      check("t2_frame", tx_packet, 128'hAA_1234_5678_9ABC_DEF0_1111_2222_3333_B0);

      // 3: frozen while cs_n low, new qw lands in the next frame
      strobe_quat(16'h4321, 16'h5678, 16'h9ABC, 16'hDEF0);
      tick();
      check("t3_frozen", tx_packet, 128'hAA_1234_5678_9ABC_DEF0_1111_2222_3333_B0);
      end_xact();
      begin_xact(1'b0, 16'h0);
      check("t3_qw_flags", {104'd0, tx_packet[119:104], tx_packet[7:0]}, 128'h4321A1);
      end_xact();

      // 4: quat strobe coincident with SNAP
      begin_xact(1'b1, 16'h7777);
      check("t4_old_qw", {112'd0, tx_packet[119:104]}, 128'h4321);
      end_xact();
      begin_xact(1'b0, 16'h0);
      check("t4_new_qw", {112'd0, tx_packet[119:104]}, 128'h7777);
      check("t4_quat_fresh", {127'd0, tx_packet[5]}, 128'd1);
      end_xact();

      // 5: reset in the middle of a transaction with cs_n held low
      begin_xact(1'b0, 16'h0);
      do_reset(2);
      base = load_cnt;
      repeat (8) tick();
      check("t5_no_load", 128'(load_cnt - base), 128'd0);
      check("t5_tx_packet", tx_packet, RESET_FRAME);
      check("t5_busy", {127'd0, busy}, 128'd0);
      check("t5_frame_seq", {124'd0, frame_seq}, 128'd0);
      cs_n = 1'b1;
      repeat (5) tick();
      begin_xact(1'b0, 16'h0);
      end_xact();

      // 6: 17 back-to-back transactions, sequence wraps
      cs_n = 1'b1;
      do_reset(2);
      repeat (5) tick();
      for (int i = 0; i < 17; i++) begin
         initialized = 1'($urandom_range(0, 1));
         error       = 1'($urandom_range(0, 1));
         if ($urandom_range(0, 1) == 1)
            strobe_quat(16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom));
         if ($urandom_range(0, 1) == 1)
            strobe_gyro(16'($urandom), 16'($urandom), 16'($urandom));
         check("t6_frame_seq", {124'd0, frame_seq}, {124'd0, m_seq});
         begin_xact(1'b0, 16'h0);
         check("t6_seq_nibble", {124'd0, tx_packet[3:0]}, 128'(i % 16));
         end_xact();
      end

      check("sb_empty", 128'(sb_q.size()), 128'd0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
